pwm_burst_array: RTL

// - Multi-channel, phase-offset PWM burst generator for the ultrasonic transmit array.
// - Successor to the single free-running 50% PWM: per-channel start delay (beam steering),

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_channel.sv | 75 +++++++
 rtl/pwm_burst_array.sv | 107 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the ultrasonic transmit PWM burst generator.
// The carrier period constant is also used by the receive-side timing.
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } burst_state_t;

    localparam int unsigned DEFAULT_PERIOD_IN_CLOCK_CYCLES = 2500;
    localparam int unsigned DEFAULT_NUM_CHANNELS           = 4;
    localparam int unsigned DEFAULT_BURST_WIDTH            = 8;

    // Width of phase/duty fields: must hold the full period value for the duty clamp.
    function automatic int unsigned phase_width(input int unsigned period);
        return $clog2(period + 1);
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One transducer channel: start delay, carrier period counter, pulse countdown.
// Counters describe the current cycle; sig_q is computed from their next values.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD      = DEFAULT_PERIOD_IN_CLOCK_CYCLES,
    parameter int unsigned PHASE_WIDTH = phase_width(PERIOD),
    parameter int unsigned BURST_WIDTH = DEFAULT_BURST_WIDTH
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   load_in,
    input  logic                   kill_in,
    input  logic [PHASE_WIDTH-1:0] offset_in,
    input  logic [PHASE_WIDTH-1:0] duty_in,
    input  logic [BURST_WIDTH-1:0] num_pulses_in,
    output logic                   sig_out,
    output logic                   done_c
);

    logic                   active_q, active_d;
    logic [PHASE_WIDTH-1:0] dly_q, dly_d;
    logic [PHASE_WIDTH-1:0] ph_q, ph_d;
    logic [BURST_WIDTH-1:0] rem_q, rem_d;
    logic                   sig_q, sig_d;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            active_q <= 1'b0;
            dly_q    <= '0;
            ph_q     <= '0;
            rem_q    <= '0;
            sig_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            dly_q    <= dly_d;
            ph_q     <= ph_d;
            rem_q    <= rem_d;
            sig_q    <= sig_d;
        end
    end

    always_comb begin
        active_d = active_q;
        dly_d    = dly_q;
        ph_d     = ph_q;
        rem_d    = rem_q;
        if (kill_in) begin
            active_d = 1'b0;
        end else if (load_in) begin
            active_d = 1'b1;
            dly_d    = offset_in;
            ph_d     = '0;
            rem_d    = num_pulses_in;
        end else if (active_q) begin
            if (dly_q != '0) begin
                dly_d = dly_q - PHASE_WIDTH'(1);
            end else if (ph_q == PHASE_WIDTH'(PERIOD - 1)) begin
                // End of a carrier period: wrap and consume one pulse.
                ph_d  = '0;
                rem_d = rem_q - BURST_WIDTH'(1);
                if (rem_q == BURST_WIDTH'(1)) begin
                    active_d = 1'b0;
                end
            end else begin
                ph_d = ph_q + PHASE_WIDTH'(1);
            end
        end
        sig_d  = active_d && (dly_d == '0) && (ph_d < duty_in);
        done_c = !active_d;
    end

    assign sig_out = sig_q;

endmodule

// File: rtl/pwm_burst_array.sv
// Multi-channel phase-offset PWM burst generator with start/busy/done handshake.
// Latches and clamps burst configuration at start, runs the channels, reports completion.
module pwm_burst_array
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS           = DEFAULT_NUM_CHANNELS,
    parameter int unsigned PERIOD_IN_CLOCK_CYCLES = DEFAULT_PERIOD_IN_CLOCK_CYCLES,
    parameter int unsigned BURST_WIDTH            = DEFAULT_BURST_WIDTH,
    parameter int unsigned PHASE_WIDTH            = phase_width(PERIOD_IN_CLOCK_CYCLES)
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                start_in,
    input  logic                                abort_in,
    input  logic [BURST_WIDTH-1:0]              num_pulses_in,
    input  logic [PHASE_WIDTH-1:0]              duty_in,
    input  logic [NUM_CHANNELS*PHASE_WIDTH-1:0] phase_offsets_in,
    output logic [NUM_CHANNELS-1:0]             sig_out,
    output logic                                busy_out,
    output logic                                done_out
);

    localparam int unsigned P = PERIOD_IN_CLOCK_CYCLES;

    burst_state_t                      state_q, state_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic [PHASE_WIDTH-1:0]            duty_q, duty_d;
    logic                              accept_c, load_c, kill_c, all_done_c;
    logic [NUM_CHANNELS-1:0]           chan_done_c;
    logic [PHASE_WIDTH-1:0]            duty_clamp_c;
    logic [NUM_CHANNELS*PHASE_WIDTH-1:0] offsets_clamp_c;

    // Out-of-range settings saturate: offset to the last phase, duty to always-high.
    always_comb begin
        duty_clamp_c = (32'(duty_in) >= P) ? PHASE_WIDTH'(P) : duty_in;
        for (int i = 0; i < int'(NUM_CHANNELS); i++) begin
            offsets_clamp_c[i*PHASE_WIDTH +: PHASE_WIDTH] =
                (32'(phase_offsets_in[i*PHASE_WIDTH +: PHASE_WIDTH]) >= P)
                    ? PHASE_WIDTH'(P - 1)
                    : phase_offsets_in[i*PHASE_WIDTH +: PHASE_WIDTH];
        end
    end

    assign accept_c   = (state_q == IDLE) && start_in && !abort_in;
    assign load_c     = accept_c && (num_pulses_in != '0);
    assign kill_c     = (state_q == RUN) && abort_in;
    assign all_done_c = &chan_done_c;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_c) state_d = RUN;
            RUN:     if (abort_in || all_done_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == RUN);
        done_d = (accept_c && (num_pulses_in == '0))
              || ((state_q == RUN) && !abort_in && all_done_c);
        duty_d = accept_c ? duty_clamp_c : duty_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            duty_q <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            duty_q <= duty_d;
        end
    end

    assign busy_out = busy_q;
    assign done_out = done_q;

    for (genvar g = 0; g < int'(NUM_CHANNELS); g++) begin : g_chan
        pwm_channel #(
            .PERIOD      (P),
            .PHASE_WIDTH (PHASE_WIDTH),
            .BURST_WIDTH (BURST_WIDTH)
        ) u_chan (
            .clk_in        (clk_in),
            .rst_in        (rst_in),
            .load_in       (load_c),
            .kill_in       (kill_c),
            .offset_in     (offsets_clamp_c[g*PHASE_WIDTH +: PHASE_WIDTH]),
            .duty_in       (duty_d),
            .num_pulses_in (num_pulses_in),
            .sig_out       (sig_out[g]),
            .done_c        (chan_done_c[g])
        );
    end

endmodule
